// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes,
// PC source codes and the opcode classification function.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_RALU    = 3'd1,
        CL_IALU    = 3'd2,
        CL_LW      = 3'd3,
        CL_SW      = 3'd4,
        CL_BEQ     = 3'd5,
        CL_JMP     = 3'd6
    } op_class_e;

    localparam logic [5:0] OP_LW  = 6'b100000;
    localparam logic [5:0] OP_SW  = 6'b100001;
    localparam logic [5:0] OP_BEQ = 6'b100010;
    localparam logic [5:0] OP_JMP = 6'b100011;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] ALU_CMP      = 4'b0001;
    localparam logic [3:0] ALU_FUNC_MAX = 4'd9;

    // ALU opcodes carry the function in the low nibble; only 0..9 are defined.
    function automatic op_class_e classify(input logic [5:0] op);
        op_class_e cls;
        cls = CL_ILLEGAL;
        case (op[5:4])
            2'b00: if (op[3:0] <= ALU_FUNC_MAX) cls = CL_RALU;
            2'b01: if (op[3:0] <= ALU_FUNC_MAX) cls = CL_IALU;
            default: begin
                case (op)
                    OP_LW:   cls = CL_LW;
                    OP_SW:   cls = CL_SW;
                    OP_BEQ:  cls = CL_BEQ;
                    OP_JMP:  cls = CL_JMP;
                    default: cls = CL_ILLEGAL;
                endcase
            end
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: instruction class plus the ALU function
// to use while the instruction executes.
import mc_pkg::*;

module mc_decode (
    input  logic [5:0] op,
    output op_class_e  op_class,
    output logic [3:0] aluc
);

    always_comb begin
        op_class = classify(op);
        case (op_class)
            CL_RALU, CL_IALU: aluc = op[3:0];
            CL_BEQ:           aluc = ALU_CMP;
            default:          aluc = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU control FSM with a memory wait timeout and sticky trap.
// Optional retired-instruction counter enabled by defining MC_CONTROL_PERF_EN.
import mc_pkg::*;

module mc_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        wmem,
    output logic        wir,
    output logic        wpc,
    output logic [1:0]  pcsrc,
    output logic [3:0]  aluc,
    output logic        aluimm,
    output logic        wreg,
    output logic        m2reg,
    output logic [2:0]  state,
    output logic        trap
`ifdef MC_CONTROL_PERF_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q;
    op_class_e  op_class;
    logic [3:0] dec_aluc;
    logic [7:0] wait_cnt;

    mc_decode u_decode (
        .op       (op),
        .op_class (op_class),
        .aluc     (dec_aluc)
    );

    assign state = state_q;

    // A cycle that sees the ack always proceeds, even when the counter is at its limit.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q  <= ST_FETCH;
            wait_cnt <= '0;
            trap     <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ack) begin
                        state_q  <= ST_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q <= ST_TRAP;
                        trap    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DECODE: begin
                    wait_cnt <= '0;
                    if (op_class == CL_ILLEGAL) begin
                        state_q <= ST_TRAP;
                        trap    <= 1'b1;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wait_cnt <= '0;
                    case (op_class)
                        CL_LW, CL_SW:   state_q <= ST_MEM;
                        CL_BEQ, CL_JMP: state_q <= ST_FETCH;
                        default:        state_q <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        wait_cnt <= '0;
                        if (op_class == CL_LW) state_q <= ST_WB;
                        else                   state_q <= ST_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q <= ST_TRAP;
                        trap    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WB: begin
                    wait_cnt <= '0;
                    state_q  <= ST_FETCH;
                end
                ST_TRAP: state_q <= ST_TRAP;
                default: begin
                    state_q <= ST_TRAP;
                    trap    <= 1'b1;
                end
            endcase
        end
    end

    // Strobes are held low for the whole time reset is asserted.
    always_comb begin
        mem_req = 1'b0;
        mem_sel = 1'b0;
        wmem    = 1'b0;
        wir     = 1'b0;
        wpc     = 1'b0;
        pcsrc   = PC_SEQ;
        aluc    = ALU_ADD;
        aluimm  = 1'b0;
        wreg    = 1'b0;
        m2reg   = 1'b0;
        if (clrn) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    wir     = mem_ack;
                    wpc     = mem_ack;
                end
                ST_EXEC: begin
                    aluc   = dec_aluc;
                    aluimm = (op_class == CL_IALU) || (op_class == CL_LW) ||
                             (op_class == CL_SW);
                    if (op_class == CL_BEQ) begin
                        pcsrc = PC_BRANCH;
                        wpc   = zero;
                    end else if (op_class == CL_JMP) begin
                        pcsrc = PC_JUMP;
                        wpc   = 1'b1;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b1;
                    wmem    = (op_class == CL_SW);
                end
                ST_WB: begin
                    wreg  = 1'b1;
                    m2reg = (op_class == CL_LW);
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CONTROL_PERF_EN
    logic retire;

    // An instruction retires when the FSM returns to FETCH from any later state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_EXEC: retire = (op_class == CL_BEQ) || (op_class == CL_JMP);
            ST_MEM:  retire = mem_ack && (op_class == CL_SW);
            ST_WB:   retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn)       instret <= '0;
        else if (retire) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles mem_req may wait for mem_ack before a trap; legal range 1..255.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clrn  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port op  in  6  opcode field from the instruction register.
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ack  in  1  memory transfer complete.
REQ-007 SHALL have port mem_req  out  1  memory access request.
REQ-008 SHALL have port mem_sel  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-009 SHALL have port wmem  out  1  memory write enable; valid only with mem_req.
REQ-010 SHALL have ports wir  out  1  IR load; wpc  out  1  PC load; pcsrc  out  2  PC source (00 = pc+4, 01 = branch target, 10 = jump target).
REQ-011 SHALL have ports aluc  out  4  ALU function; aluimm  out  1  ALU B operand = immediate; wreg  out  1  register-file write; m2reg  out  1  write-back source = memory.
REQ-012 SHALL have ports state  out  3  current FSM state; trap  out  1  sticky fault flag.

Function
REQ-013 SHALL classify op as follows:
- 00xxxx with xxxx <= 1001: R-type ALU, aluc = xxxx.
- 01xxxx with xxxx <= 1001: I-type ALU, aluc = xxxx, aluimm = 1.
- 100000: LW. 100001: SW. 100010: BEQ. 100011: JMP.
- All other values: illegal.
REQ-014 SHALL implement states FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
REQ-015 In FETCH, SHALL assert mem_req = 1 and mem_sel = 0.
- On mem_ack, SHALL assert wir = 1, wpc = 1 and pcsrc = 00 in that same cycle, then go to DECODE.
- Without mem_ack, SHALL stay in FETCH.
REQ-016 DECODE SHALL last exactly one cycle: illegal op goes to TRAP; every other op goes to EXEC.
REQ-017 EXEC SHALL drive aluc and aluimm for the decoded class and take exactly one cycle:
- ALU ops go to WB.
- LW/SW drive aluc = 0000 with aluimm = 1, then go to MEM.
- BEQ drives aluc = 0001 with aluimm = 0; if zero = 1, assert wpc = 1 with pcsrc = 01; then go to FETCH.
- JMP asserts wpc = 1 with pcsrc = 10, then goes to FETCH.
REQ-018 In MEM, SHALL assert mem_req = 1 and mem_sel = 1, with wmem = 1 for SW only. On mem_ack, SW goes to FETCH and LW goes to WB.
REQ-019 WB SHALL last exactly one cycle with wreg = 1 and m2reg = 1 for LW only, then go to FETCH.
REQ-020 With mem_ack held at 1, latencies SHALL be: ALU op 4 cycles; LW 5; SW 4; BEQ 3; JMP 3.
REQ-021 mem_ack SHALL be ignored in every state where mem_req = 0.
REQ-022 A wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle of mem_req without mem_ack. If it reaches MEM_TIMEOUT, the FSM SHALL go to TRAP.
REQ-023 If mem_ack arrives in the same cycle the counter reaches MEM_TIMEOUT, the ack SHALL win and the FSM SHALL proceed normally.
REQ-024 TRAP SHALL deassert every enable and mem_req and set trap = 1. The FSM SHALL remain in TRAP until reset.
REQ-025 All outputs except state and trap SHALL be combinational from state, op and the handshake inputs.

Reset
REQ-026 clrn = 0 at a clock edge SHALL force state = FETCH, wait counter = 0 and trap = 0, aborting any transfer in progress.
REQ-027 While clrn = 0, all enables and mem_req SHALL be 0.

Configuration
REQ-028 With MC_CONTROL_PERF_EN defined, the block SHALL add output instret (32 bits).
- instret is reset to 0.
- It increments by 1 on every transition into FETCH from EXEC, MEM or WB, and wraps from 0xFFFFFFFF to 0.
- Without the macro, the port and its counter SHALL be absent.

Structure
REQ-029 State encodings, opcode constants, pcsrc codes and class decode SHALL reside in a shared package, mc_pkg.
REQ-030 Opcode classification SHALL be one sub-module, mc_decode (combinational, op in, class and aluc out).

Verification
REQ-031 Reset then op = 000000, mem_ack = 1 -> states 0,1,2,4,0; wreg pulses once in cycle 4; wpc = 1 in cycle 1.
REQ-032 op = 100000, mem_ack low 3 cycles in MEM then high -> MEM held 4 cycles, wmem = 0, then WB with m2reg = 1.
REQ-033 op = 100010, zero = 1 -> EXEC shows wpc = 1 and pcsrc = 01; with zero = 0 -> wpc = 0.
REQ-034 op = 111111 -> DECODE then TRAP, trap = 1 and held; clrn = 0 for one edge -> state = 0, trap = 0.
REQ-035 mem_ack stuck 0 in FETCH -> TRAP after exactly 15 cycles; ack arriving on cycle 15 -> DECODE, no trap.
REQ-036 PERF_EN build, 3 ALU instructions -> instret = 3; clrn = 0 during MEM -> instret = 0, state = FETCH.
